// File: rtl/tour_cmd.sv
// rtl/tour_cmd.sv - replays a 24-move knight tour as two-leg movement commands,
// otherwise passes UART commands straight through to the command processor.
module tour_cmd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;
  localparam logic [4:0] LAST_MOVE = 5'd23;

  typedef enum logic [2:0] {IDLE, LEG1, WAIT1, LEG2, WAIT2} state_t;

  state_t      state, state_nxt;
  logic [4:0]  indx_nxt;
  logic [7:0]  hdg1, hdg2;
  logic [15:0] leg1, leg2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= 5'd0;
    end else begin
      state   <= state_nxt;
      mv_indx <= indx_nxt;
    end
  end

  // Lowest set bit of the one-hot move wins if the solver ever presents several.
  always_comb begin
    hdg1 = HDG_N;
    hdg2 = HDG_N;
    casez (move)
      8'b???????1: begin hdg1 = HDG_N; hdg2 = HDG_E; end
      8'b??????10: begin hdg1 = HDG_N; hdg2 = HDG_W; end
      8'b?????100: begin hdg1 = HDG_W; hdg2 = HDG_N; end
      8'b????1000: begin hdg1 = HDG_W; hdg2 = HDG_S; end
      8'b???10000: begin hdg1 = HDG_S; hdg2 = HDG_W; end
      8'b??100000: begin hdg1 = HDG_S; hdg2 = HDG_E; end
      8'b?1000000: begin hdg1 = HDG_E; hdg2 = HDG_S; end
      8'b10000000: begin hdg1 = HDG_E; hdg2 = HDG_N; end
      default:     begin hdg1 = HDG_N; hdg2 = HDG_N; end
    endcase
  end

  // An empty move degrades to a zero-length north move on both legs.
  assign leg1 = (move == 8'h00) ? 16'h4000 : {4'h4, hdg1, 4'h2};
  assign leg2 = (move == 8'h00) ? 16'h4000 : {4'h5, hdg2, 4'h1};

  always_comb begin
    state_nxt        = state;
    indx_nxt         = mv_indx;
    cmd              = cmd_UART;
    cmd_rdy          = cmd_rdy_UART;
    clr_cmd_rdy_UART = clr_cmd_rdy;
    resp             = 8'hA5;
    case (state)
      IDLE: begin
        resp = 8'h5A;
        if (start_tour) begin
          state_nxt = LEG1;
          indx_nxt  = 5'd0;
        end
      end
      LEG1: begin
        cmd              = leg1;
        cmd_rdy          = 1'b1;
        clr_cmd_rdy_UART = 1'b0;
        if (clr_cmd_rdy) state_nxt = WAIT1;
      end
      WAIT1: begin
        cmd              = leg1;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        if (send_resp) state_nxt = LEG2;
      end
      LEG2: begin
        cmd              = leg2;
        cmd_rdy          = 1'b1;
        clr_cmd_rdy_UART = 1'b0;
        if (clr_cmd_rdy) state_nxt = WAIT2;
      end
      WAIT2: begin
        cmd              = leg2;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        if (mv_indx == LAST_MOVE) resp = 8'h5A;
        if (send_resp) begin
          if (mv_indx == LAST_MOVE) begin
            state_nxt = IDLE;
          end else begin
            indx_nxt  = mv_indx + 5'd1;
            state_nxt = LEG1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start_tour  in  1  one-cycle pulse; begins tour replay.
REQ-004 SHALL have ports: move  in  8  one-hot knight move for the current mv_indx, from tour solver.
REQ-005 SHALL have ports: mv_indx  out  5  index of the move being replayed, 0..23.
REQ-006 SHALL have ports: cmd_UART  in  16  command from UART wrapper.
REQ-007 SHALL have ports: cmd_rdy_UART  in  1  cmd_UART valid.
REQ-008 SHALL have ports: clr_cmd_rdy_UART  out  1  consume strobe to UART wrapper.
REQ-009 SHALL have ports: cmd  out  16  command to command processor.
REQ-010 SHALL have ports: cmd_rdy  out  1  cmd valid.
REQ-011 SHALL have ports: clr_cmd_rdy  in  1  command processor consumed cmd.
REQ-012 SHALL have ports: send_resp  in  1  command processor finished a command.
REQ-013 SHALL have ports: resp  out  8  response byte: 8'hA5 (move done, more follow) or 8'h5A (done).

Function
REQ-014 SHALL use command format: cmd[15:12] opcode, 4'h4 move or 4'h5 move-with-fanfare; cmd[11:4] heading; cmd[3:0] squares.
REQ-015 SHALL use headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
REQ-016 SHALL implement FSM states IDLE, LEG1, WAIT1, LEG2, WAIT2.
REQ-017 In IDLE: cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, clr_cmd_rdy_UART = clr_cmd_rdy, and resp = 8'h5A.
REQ-018 In IDLE with start_tour: next state LEG1 and mv_indx <= 0.
REQ-019 Outside IDLE: clr_cmd_rdy_UART = 0 and cmd_rdy_UART is ignored, so a pending UART command is held, not dropped.
REQ-020 LEG1/LEG2: cmd_rdy = 1; on clr_cmd_rdy, advance to WAIT1/WAIT2 respectively.
REQ-021 WAIT1/WAIT2: cmd_rdy = 0; cmd holds the last leg value.
REQ-022 WAIT1 with send_resp: go to LEG2.
REQ-023 WAIT2 with send_resp: if mv_indx == 23, go to IDLE; else mv_indx <= mv_indx+1 and go to LEG1.
REQ-024 Leg 1 SHALL be the 2-square leg with opcode 4'h4; leg 2 SHALL be the 1-square leg with opcode 4'h5.
REQ-025 SHALL decode move bits as follows:
  - bit0: N2 then E1
  - bit1: N2 then W1
  - bit2: W2 then N1
  - bit3: W2 then S1
  - bit4: S2 then W1
  - bit5: S2 then E1
  - bit6: E2 then S1
  - bit7: E2 then N1
REQ-026 With multiple bits set in move, the lowest set bit SHALL win.
REQ-027 With move == 0, both legs SHALL be 16'h4000.
REQ-028 resp SHALL be 8'h5A in IDLE and in WAIT2 when mv_indx == 23; otherwise 8'hA5.
REQ-029 resp SHALL be combinational and valid in the cycle send_resp is high.
REQ-030 cmd and cmd_rdy in tour states SHALL decode from registered state, mv_indx and move, with no extra pipeline delay.
REQ-031 cmd_rdy SHALL rise the cycle after start_tour is sampled.
REQ-032 start_tour SHALL be ignored outside IDLE.
REQ-033 clr_cmd_rdy outside LEG1/LEG2 and send_resp outside WAIT1/WAIT2 SHALL be ignored while in a tour state.
REQ-034 Simultaneous clr_cmd_rdy and send_resp in LEG1/LEG2 SHALL act on clr_cmd_rdy only.
REQ-035 mv_indx SHALL never exceed 23 and SHALL NOT wrap.

Reset
REQ-036 On rst_n low, SHALL immediately enter IDLE with mv_indx = 0; outputs then follow IDLE passthrough.
REQ-037 Reset asserted mid-tour SHALL abort the tour; no further tour commands are issued after release until the next start_tour.

Verification
REQ-038 Passthrough: in IDLE with cmd_UART = 16'h4BF1, cmd_rdy_UART = 1, pulse clr_cmd_rdy -> cmd = 16'h4BF1, cmd_rdy = 1, clr_cmd_rdy_UART pulses the same cycle, resp = 8'h5A.
REQ-039 Single move: start_tour, move = 8'h01 -> next cycle cmd = 16'h4002, cmd_rdy = 1; after clr_cmd_rdy and send_resp (resp 8'hA5) -> cmd = 16'h5BF1.
REQ-040 Full tour: 24 moves with cycling one-hot move values -> 48 legs issued, mv_indx steps 0..23, exactly one 8'h5A at the final send_resp, then IDLE.
REQ-041 Arbitration: cmd_rdy_UART held high during the tour -> clr_cmd_rdy_UART never pulses and cmd never equals cmd_UART; after the tour, cmd_UART is passed through.
REQ-042 Boundaries: move = 8'h18 -> leg1 = 16'h43F2, leg2 = 16'h57F1; move = 8'h00 -> both legs 16'h4000; start_tour during WAIT1 -> no effect.
REQ-043 Reset in WAIT2 at mv_indx = 10 -> IDLE, mv_indx = 0, cmd_rdy = cmd_rdy_UART.
